// File: rtl/sha1_wb_master_if.sv
// Wishbone bus bundle between the SHA1 block-hash initiator and the peripheral.
interface sha1_wb_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/sha1_wb_master.sv
// Wishbone initiator running one 512-bit SHA1 block through the peripheral:
// ON command, 16 message writes, DONE polling, 5 digest reads.
module sha1_wb_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_LIMIT   = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             msg_valid,
  input  logic [31:0]      msg_data,
  output logic             msg_ready,
  output logic             busy,
  output logic             digest_valid,
  output logic [159:0]     digest_data,
  output logic             error,
  sha1_wb_master_if.master wbm
);
  localparam logic [31:0] OPS_ADR = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] MSG_ADR = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] DIG_ADR = BASE_ADDRESS + 32'h10;
  localparam logic [31:0] EBUSY   = 32'hffff_fff0;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_MSG, S_MSG_WR, S_POLL, S_DIG, S_FIN, S_ERR
  } state_t;

  // Every bus transfer walks GAP (cyc low) -> STB (one strobe) -> WAIT (cyc held).
  typedef enum logic [1:0] { PH_GAP, PH_STB, PH_WAIT } phase_t;

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      word_cnt_q, word_cnt_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [2:0]      dig_cnt_q, dig_cnt_d;
  logic [31:0]     msg_q, msg_d;
  logic [159:0]    digest_q, digest_d;
  logic            error_q, error_d;

  logic xfer_state, in_cyc, ack_ok;

  assign xfer_state = (state_q == S_CMD) || (state_q == S_MSG_WR) ||
                      (state_q == S_POLL) || (state_q == S_DIG);
  assign in_cyc     = xfer_state && (phase_q != PH_GAP);
  assign ack_ok     = in_cyc && wbm.wbm_ack_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_GAP;
      timer_q    <= '0;
      word_cnt_q <= '0;
      poll_cnt_q <= '0;
      dig_cnt_q  <= '0;
      msg_q      <= '0;
      digest_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      word_cnt_q <= word_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      dig_cnt_q  <= dig_cnt_d;
      msg_q      <= msg_d;
      digest_q   <= digest_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    timer_d    = timer_q;
    word_cnt_d = word_cnt_q;
    poll_cnt_d = poll_cnt_q;
    dig_cnt_d  = dig_cnt_q;
    msg_d      = msg_q;
    digest_d   = digest_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          word_cnt_d = '0;
          poll_cnt_d = '0;
          dig_cnt_d  = '0;
          phase_d    = PH_STB;
          state_d    = S_CMD;
        end
      end
      S_MSG: begin
        if (msg_valid) begin
          msg_d   = msg_data;
          phase_d = PH_STB;
          state_d = S_MSG_WR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: begin
        case (phase_q)
          PH_GAP: phase_d = PH_STB;
          PH_STB: begin
            phase_d = PH_WAIT;
            timer_d = TW'(1);
          end
          default: begin
            timer_d = timer_q + TW'(1);
            // Last cycle in which an ack is still accepted is stb + ACK_TIMEOUT - 1.
            if (!wbm.wbm_ack_i && timer_q == TW'(ACK_TIMEOUT - 1)) begin
              phase_d = PH_GAP;
              state_d = S_ERR;
            end
          end
        endcase

        if (ack_ok) begin
          phase_d = PH_GAP;
          case (state_q)
            S_CMD: state_d = S_MSG;
            S_MSG_WR: begin
              word_cnt_d = word_cnt_q + 4'd1;
              state_d    = (word_cnt_q == 4'd15) ? S_POLL : S_MSG;
            end
            S_POLL: begin
              if (wbm.wbm_dat_i[3]) begin
                dig_cnt_d = '0;
                state_d   = S_DIG;
              end else begin
                poll_cnt_d = poll_cnt_q + PW'(1);
                if (poll_cnt_q == PW'(POLL_LIMIT - 1))
                  state_d = S_ERR;
              end
            end
            default: begin
              if (wbm.wbm_dat_i == EBUSY) begin
                state_d = S_ERR;
              end else begin
                digest_d[{dig_cnt_q, 5'd0} +: 32] = wbm.wbm_dat_i;
                dig_cnt_d = dig_cnt_q + 3'd1;
                if (dig_cnt_q == 3'd4)
                  state_d = S_FIN;
              end
            end
          endcase
        end
      end
    endcase

    if (state_d == S_ERR)
      error_d = 1'b1;
  end

  always_comb begin
    wbm.wbm_adr_o = '0;
    wbm.wbm_dat_o = '0;
    if (in_cyc) begin
      case (state_q)
        S_CMD: begin
          wbm.wbm_adr_o = OPS_ADR;
          wbm.wbm_dat_o = 32'h1;
        end
        S_MSG_WR: begin
          wbm.wbm_adr_o = MSG_ADR;
          wbm.wbm_dat_o = msg_q;
        end
        S_POLL:  wbm.wbm_adr_o = OPS_ADR;
        default: wbm.wbm_adr_o = DIG_ADR;
      endcase
    end
  end

  assign wbm.wbm_cyc_o = in_cyc;
  assign wbm.wbm_stb_o = xfer_state && (phase_q == PH_STB);
  assign wbm.wbm_we_o  = in_cyc && ((state_q == S_CMD) || (state_q == S_MSG_WR));
  assign wbm.wbm_sel_o = in_cyc ? 4'hF : 4'h0;

  assign msg_ready    = (state_q == S_MSG);
  assign busy         = xfer_state || (state_q == S_MSG);
  assign digest_valid = (state_q == S_FIN);
  assign digest_data  = digest_q;
  assign error        = error_q;
endmodule

// File: tb/tb_sha1_wb_master.sv
// Directed bench for sha1_wb_master with a scripted Wishbone responder and protocol monitor.
module tb_sha1_wb_master;
  localparam logic [31:0]  OPS     = 32'h3000_002C;
  localparam logic [31:0]  MSGIN   = 32'h3000_0030;
  localparam logic [31:0]  DIGA    = 32'h3000_0034;
  localparam logic [159:0] EXP_DIG = 160'hc3d2e1f0_10325476_98badcfe_efcdab89_67452301;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         msg_valid = 1'b0;
  logic [31:0]  msg_data = '0;
  logic         msg_ready, busy, digest_valid, error;
  logic [159:0] digest_data;

  sha1_wb_master_if bus();

  sha1_wb_master dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .start        (start),
    .msg_valid    (msg_valid),
    .msg_data     (msg_data),
    .msg_ready    (msg_ready),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest_data  (digest_data),
    .error        (error),
    .wbm          (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return 32'hA500_0000 + 32'(k) * 32'h0001_0101;
  endfunction

  // ---------------- responder ----------------
  logic [31:0] dig_words [5];
  initial begin
    dig_words[0] = 32'h6745_2301;
    dig_words[1] = 32'hefcd_ab89;
    dig_words[2] = 32'h98ba_dcfe;
    dig_words[3] = 32'h1032_5476;
    dig_words[4] = 32'hc3d2_e1f0;
  end

  logic [64:0] xlog [512];
  int n_xfer = 0, n_ops_rd = 0, n_msg_wr = 0, n_dig_rd = 0;
  int base_x = 0, base_ops = 0, base_msg = 0, base_dig = 0;
  int done_after = 0, drop_idx = 99, ebusy_idx = 99;
  bit stray_ack = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_dat_i <= '0;
    end else begin
      bus.wbm_ack_i <= 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
        if (n_xfer < 512)
          xlog[n_xfer] <= {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_we_o ? bus.wbm_dat_o : 32'h0};
        n_xfer <= n_xfer + 1;
        if (bus.wbm_we_o) begin
          if (bus.wbm_adr_o == MSGIN) begin
            n_msg_wr <= n_msg_wr + 1;
            if (n_msg_wr - base_msg != drop_idx) bus.wbm_ack_i <= 1'b1;
          end else begin
            bus.wbm_ack_i <= 1'b1;
          end
        end else if (bus.wbm_adr_o == OPS) begin
          bus.wbm_dat_i <= (n_ops_rd - base_ops >= done_after) ? 32'h8 : 32'h0;
          n_ops_rd      <= n_ops_rd + 1;
          bus.wbm_ack_i <= 1'b1;
        end else if (bus.wbm_adr_o == DIGA) begin
          bus.wbm_dat_i <= (n_dig_rd - base_dig == ebusy_idx) ? 32'hffff_fff0
                                                               : dig_words[(n_dig_rd - base_dig) % 5];
          n_dig_rd      <= n_dig_rd + 1;
          bus.wbm_ack_i <= 1'b1;
        end else begin
          bus.wbm_dat_i <= '0;
          bus.wbm_ack_i <= 1'b1;
        end
      end else if (stray_ack && msg_ready && !msg_valid) begin
        // DUT stays in its message-wait state next cycle, so this ack lands with cyc low.
        bus.wbm_ack_i <= 1'b1;
        bus.wbm_dat_i <= 32'hdead_beef;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  logic        stb_prev = 1'b0, cyc_prev = 1'b0, hs_prev = 1'b0;
  logic [64:0] held = '0;
  int viol = 0, dv_cnt = 0, run_len = 0, last_len = 0;
  logic [159:0] dv_data = '0;

  always @(negedge clk) begin
    if (bus.wbm_stb_o && stb_prev) viol <= viol + 1;
    if (bus.wbm_stb_o && cyc_prev) viol <= viol + 1;
    if (bus.wbm_cyc_o && !cyc_prev && !bus.wbm_stb_o) viol <= viol + 1;
    if (bus.wbm_cyc_o && bus.wbm_sel_o != 4'hF) viol <= viol + 1;
    if (hs_prev && msg_ready) viol <= viol + 1;
    if (bus.wbm_stb_o)
      held <= {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o};
    else if (bus.wbm_cyc_o && held != {bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o})
      viol <= viol + 1;
    if (bus.wbm_cyc_o) begin
      run_len <= run_len + 1;
    end else begin
      if (run_len != 0) last_len <= run_len;
      run_len <= 0;
    end
    if (digest_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_data <= digest_data;
    end
    stb_prev <= bus.wbm_stb_o;
    cyc_prev <= bus.wbm_cyc_o;
    hs_prev  <= msg_valid && msg_ready;
  end

  // ---------------- stimulus helpers ----------------
  int dv_base = 0, viol_base = 0;

  task automatic mark();
    @(negedge clk);
    base_x    = n_xfer;
    base_ops  = n_ops_rd;
    base_msg  = n_msg_wr;
    base_dig  = n_dig_rd;
    dv_base   = dv_cnt;
    viol_base = viol;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    for (int k = 0; k < 16; k++) begin
      int c;
      if (!busy) break;
      if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = word(k);
      c = 0;
      while (!msg_ready && busy && c < 1000) begin
        @(negedge clk);
        c++;
      end
      if (msg_ready) @(negedge clk);
      msg_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check(tag, 160'(busy), 160'(0));
    @(negedge clk);
  endtask

  task automatic check_clean_run(input string tag, input int polls);
    check({tag, "_nx"}, 160'(n_xfer - base_x), 160'(22 + polls));
    check({tag, "_cmd"}, 160'(xlog[base_x]), 160'({1'b1, OPS, 32'h1}));
    for (int k = 0; k < 16; k++)
      check({tag, "_msg"}, 160'(xlog[base_x + 1 + k]), 160'({1'b1, MSGIN, word(k)}));
    for (int p = 0; p < polls; p++)
      check({tag, "_poll"}, 160'(xlog[base_x + 17 + p]), 160'({1'b0, OPS, 32'h0}));
    for (int i = 0; i < 5; i++)
      check({tag, "_dig"}, 160'(xlog[base_x + 17 + polls + i]), 160'({1'b0, DIGA, 32'h0}));
    check({tag, "_dvcnt"}, 160'(dv_cnt - dv_base), 160'(1));
    check({tag, "_dvdata"}, dv_data, EXP_DIG);
    check({tag, "_digest"}, digest_data, EXP_DIG);
    check({tag, "_err"}, 160'(error), 160'(0));
    check({tag, "_proto"}, 160'(viol - viol_base), 160'(0));
    $display("hash %s: xfers=%0d polls=%0d digest=%h", tag, n_xfer - base_x, n_ops_rd - base_ops, digest_data);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c;
    repeat (3) @(negedge clk);
    check("rst_cyc",    160'(bus.wbm_cyc_o), 160'(0));
    check("rst_stb",    160'(bus.wbm_stb_o), 160'(0));
    check("rst_busy",   160'(busy), 160'(0));
    check("rst_ready",  160'(msg_ready), 160'(0));
    check("rst_dv",     160'(digest_valid), 160'(0));
    check("rst_err",    160'(error), 160'(0));
    check("rst_digest", digest_data, 160'(0));
    check("rst_adr",    160'(bus.wbm_adr_o), 160'(0));
    rst = 1'b0;

    // nominal
    mark();
    pulse_start();
    check("nom_busy", 160'(busy), 160'(1));
    feed(1'b0);
    wait_idle("nom_done");
    check_clean_run("nom", 1);

    // random msg_valid gaps plus acks outside an open cycle
    stray_ack = 1'b1;
    mark();
    pulse_start();
    feed(1'b1);
    wait_idle("gap_done");
    check_clean_run("gap", 1);
    stray_ack = 1'b0;

    // DONE clear for 3 polls
    done_after = 3;
    mark();
    pulse_start();
    feed(1'b0);
    wait_idle("poll_done");
    check("poll_opsrd", 160'(n_ops_rd - base_ops), 160'(4));
    check_clean_run("poll", 4);
    done_after = 0;

    // 5th message write never acknowledged
    drop_idx = 4;
    mark();
    pulse_start();
    feed(1'b0);
    wait_idle("to_done");
    check("to_err",    160'(error), 160'(1));
    check("to_busy",   160'(busy), 160'(0));
    check("to_cyclen", 160'(last_len), 160'(16));
    check("to_msgwr",  160'(n_msg_wr - base_msg), 160'(5));
    check("to_dv",     160'(dv_cnt - dv_base), 160'(0));
    drop_idx = 99;
    mark();
    pulse_start();
    check("to_errclr", 160'(error), 160'(0));
    feed(1'b0);
    wait_idle("rerun_done");
    check_clean_run("rerun", 1);

    // EBUSY on the third digest read
    ebusy_idx = 2;
    mark();
    pulse_start();
    feed(1'b0);
    wait_idle("eb_done");
    check("eb_err",   160'(error), 160'(1));
    check("eb_dv",    160'(dv_cnt - dv_base), 160'(0));
    check("eb_digrd", 160'(n_dig_rd - base_dig), 160'(3));
    ebusy_idx = 99;

    // reset asserted mid-poll
    done_after = 1000;
    mark();
    pulse_start();
    feed(1'b0);
    c = 0;
    while ((n_ops_rd - base_ops < 3 || !bus.wbm_cyc_o) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("mr_incyc", 160'(bus.wbm_cyc_o), 160'(1));
    #1 rst = 1'b1;
    #1;
    check("mr_cyc",    160'(bus.wbm_cyc_o), 160'(0));
    check("mr_stb",    160'(bus.wbm_stb_o), 160'(0));
    check("mr_busy",   160'(busy), 160'(0));
    check("mr_digest", digest_data, 160'(0));
    @(negedge clk);
    rst = 1'b0;
    done_after = 0;
    mark();
    pulse_start();
    feed(1'b0);
    wait_idle("post_done");
    check_clean_run("post", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sha1_wb_master.md
Name: sha1_wb_master

Overview:
- Wishbone initiator that drives the SHA1 peripheral's register map. It uses that map to run one complete 512-bit block hash: it issues the ON command, writes 16 message words, polls the ops register until DONE, then reads 5 digest words.
- Sits between a local stream source (message words in, digest out) and the Caravel-side Wishbone bus, so user logic can hash without a CPU.

Parameters:
- BASE_ADDRESS, 32'h30000024, peripheral base; CTRL_SHA1_OPS=+0x8, CTRL_MSG_IN=+0xC, CTRL_SHA1_DIGEST=+0x10.
- ACK_TIMEOUT, 16, maximum cycles to wait for wbm_ack_i after the strobe before aborting.
- POLL_LIMIT, 1024, maximum ops-register reads without DONE before aborting.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin a hash; ignored unless idle
- msg_valid  in  1  message word available
- msg_data  in  32  message word; word k lands at message[32k+31:32k]
- msg_ready  out  1  word accepted when msg_valid&msg_ready
- busy  out  1  high from the accepted start until done or error
- digest_valid  out  1  one-cycle pulse; digest_data valid
- digest_data  out  160  [31:0]=first digest read ... [159:128]=fifth
- error  out  1  sticky; set on timeout or EBUSY; cleared by next accepted start
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  always 4'hF during a transfer
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  acknowledge
- wbm_dat_i  in  32  read data

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; digest_data=0; counters 0.

Transfer rule (the responder acts on every cycle stb&cyc is high):
- wbm_stb_o is high for exactly one cycle per transfer.
- wbm_cyc_o rises with stb and stays high until the cycle wbm_ack_i is sampled high, inclusive; it falls the next cycle.
- adr/we/dat/sel are held stable from the strobe until the ack.
- At least one idle cycle (cyc=0) separates transfers.
- Timeout: if no ack arrives within ACK_TIMEOUT cycles after the strobe, go to ERR.

States:
- IDLE: on start, clear error, word counter and poll counter; busy=1; go to CMD.
- CMD: write 32'h1 to OPS; on ack, go to MSG.
- MSG: msg_ready=1. On handshake, latch the word and go to MSG_WR; msg_ready drops the cycle after the handshake.
- MSG_WR: write the latched word to MSG_IN; on ack, counter+1. If counter was 15, go to POLL; otherwise go to MSG.
- POLL: read OPS; on ack, test bit 3 (DONE).
  - Set: go to DIG.
  - Clear: poll counter+1; if it reaches POLL_LIMIT, go to ERR; otherwise re-poll after the idle cycle.
- DIG: read DIGEST 5 times; read i (0..4) goes to digest_data[32i+31:32i].
  - A returned word of 32'hfffffff0 (EBUSY) goes to ERR.
  - After the 5th ack, go to FIN.
- FIN: digest_valid=1 for one cycle; busy=0; go to IDLE.
- ERR: drop cyc/stb; error=1; busy=0; go to IDLE. error holds until the next accepted start.

Boundary conditions:
- start while busy: ignored.
- msg_valid is never required to be continuous; the FSM stalls in MSG indefinitely without a timeout.
- An ack that arrives outside an open cycle (cyc=0) is ignored.
- Reset mid-transfer: cyc/stb drop immediately (asynchronously) and the partial digest is discarded.
- Address arithmetic: BASE_ADDRESS + offset, truncated to 32 bits.

Test Plan:
- Nominal, responder acks 1 cycle after stb, DONE on first poll, digest words 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0 -> bus sequence is:
  - 1 write of 0x1 to 0x3000002C
  - 16 writes to 0x30000030
  - 1 read of 0x3000002C
  - 5 reads of 0x30000034
  - then digest_data = c3d2e1f0_10325476_98badcfe_efcdab89_67452301 and digest_valid high for 1 cycle.
- Message words 0..15 supplied with random msg_valid gaps -> responder receives them in order; stb is exactly 1 cycle per transfer; no transfer is issued while msg_valid is low.
- DONE deasserted for 3 polls, then set -> exactly 4 OPS reads, then the digest phase; error=0.
- Responder never acks the 5th message write -> cyc drops ACK_TIMEOUT cycles after the stb; error=1; busy=0; a new start clears error.
- Digest read returns 32'hfffffff0 -> ERR; digest_valid never pulses.
- wb_rst_i asserted mid-poll -> cyc/stb/busy go to 0 within the same cycle; a subsequent start runs a full clean sequence.
